// File: rtl/addsub_seq_pkg.sv
// ---------------------------------------------------------------------------
// addsub_seq_pkg
// Shared definitions for the chunk-serial adder/subtractor:
//   - FSM state encoding (IDLE / RUN / DONE)
//   - bit positions of the captured {packed, sat, sub} mode word
//   - encode_mode(): packs the three mode inputs into that word
// ---------------------------------------------------------------------------
package addsub_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned MODE_SUB    = 0;
    localparam int unsigned MODE_SAT    = 1;
    localparam int unsigned MODE_PACKED = 2;
    localparam int unsigned MODE_W      = 3;

    typedef logic [MODE_W-1:0] mode_t;

    function automatic mode_t encode_mode(input logic packed_en,
                                          input logic sat,
                                          input logic sub);
        mode_t m;
        m              = '0;
        m[MODE_PACKED] = packed_en;
        m[MODE_SAT]    = sat;
        m[MODE_SUB]    = sub;
        return m;
    endfunction

endpackage

// File: rtl/addsub_chunk.sv
// ---------------------------------------------------------------------------
// addsub_chunk
// CHUNK-bit ripple adder built from full_adder_1bit. The caller supplies the
// already-inverted B operand for subtraction; this block only adds.
//   a_i, b_i : CHUNK-bit addends
//   cin_i    : carry into bit 0
//   s_o      : CHUNK-bit sum
//   cout_o   : carry out of the MSB
//   cmsb_o   : carry into the MSB (XOR with cout_o gives signed overflow)
// ---------------------------------------------------------------------------
module addsub_chunk #(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             cin_i,
    output logic [CHUNK-1:0] s_o,
    output logic             cout_o,
    output logic             cmsb_o
);

    logic [CHUNK:0] c;

    assign c[0] = cin_i;

    for (genvar i = 0; i < CHUNK; i++) begin : gen_fa
        full_adder_1bit u_fa (
            .a_i    (a_i[i]),
            .b_i    (b_i[i]),
            .cin_i  (c[i]),
            .s_o    (s_o[i]),
            .cout_o (c[i+1])
        );
    end

    assign cout_o = c[CHUNK];
    assign cmsb_o = c[CHUNK-1];

endmodule

// File: rtl/full_adder_1bit.sv
// ---------------------------------------------------------------------------
// full_adder_1bit
// Single-bit full adder, the building block of the chunk ripple adder.
//   a_i, b_i, cin_i : addend bits and carry in
//   s_o, cout_o     : sum bit and carry out
// ---------------------------------------------------------------------------
module full_adder_1bit (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic s_o,
    output logic cout_o
);

    logic p;

    assign p      = a_i ^ b_i;
    assign s_o    = p ^ cin_i;
    assign cout_o = (a_i & b_i) | (cin_i & p);

endmodule

// File: rtl/addsub_seq.sv
// ---------------------------------------------------------------------------
// addsub_seq
// Chunk-serial two's-complement adder/subtractor with saturation, packed
// lanes and N/Z/V flags. One CHUNK-wide segment is added per RUN cycle
// (LSB first); one further RUN cycle applies saturation and computes flags.
//
// Ports
//   clk, rst           : clock, synchronous active-high reset
//   in_valid/in_ready  : operand handshake (in_ready high only in IDLE)
//   A, B               : WIDTH-bit two's-complement operands
//   sub                : 1 = A-B, 0 = A+B
//   sat                : saturate on overflow (whole word or per lane)
//   packed_en          : independent CHUNK-wide lanes, no inter-lane carry
//                        ("packed" is a reserved word, hence the name)
//   out_valid/out_ready: result handshake
//   Sum, Ovfl, Zero, Neg: result and flags, meaningful while out_valid=1
//
// Timing: accept at edge T, out_valid at edge T+NCHUNK+1.
// WIDTH must be a multiple of CHUNK; CHUNK == WIDTH is legal.
// ---------------------------------------------------------------------------
module addsub_seq
    import addsub_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             sub,
    input  logic             sat,
    input  logic             packed_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Ovfl,
    output logic             Zero,
    output logic             Neg
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    // Counter runs 0..NCHUNK: values below NCHUNK select a chunk, NCHUNK is
    // the adjust cycle that keeps saturation off the adder path.
    localparam int unsigned CW      = $clog2(NCHUNK + 1);
    localparam logic [CW-1:0] ADJ_CNT = CW'(NCHUNK);

    localparam logic [CHUNK-1:0] LANE_MAX = {CHUNK{1'b1}} >> 1;
    localparam logic [CHUNK-1:0] LANE_MIN = ~LANE_MAX;
    localparam logic [WIDTH-1:0] WORD_MAX = {WIDTH{1'b1}} >> 1;
    localparam logic [WIDTH-1:0] WORD_MIN = ~WORD_MAX;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q;
    logic              carry_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  bx_q;
    mode_t             mode_q;
    logic [WIDTH-1:0]  sum_q;
    logic [NCHUNK-1:0] v_q;
    logic              ovfl_q, zero_q, neg_q;

    logic [CHUNK-1:0]  a_chunk, b_chunk, s_chunk;
    logic              cin, cout, cmsb, v_cur;
    logic [WIDTH-1:0]  sum_run, sum_fin;
    logic [NCHUNK-1:0] v_run;
    logic              ovfl_fin;
    logic              accept;

    assign accept = in_valid && in_ready;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: assigning a default before the case keeps every path
        // covered, so no latch is inferred.
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)            state_d = RUN;
            RUN:     if (cnt_q == ADJ_CNT)  state_d = DONE;
            DONE:    if (out_ready)         state_d = IDLE;
            default:                        state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // ------------------------------------------------------------------
    // Chunk select and per-chunk result merge
    // ------------------------------------------------------------------
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (cnt_q == CW'(i)) begin
                a_chunk = a_q[i*CHUNK +: CHUNK];
                b_chunk = bx_q[i*CHUNK +: CHUNK];
            end
        end
    end

    // Packed lanes each restart with cin=sub; word mode chains the carry.
    assign cin = mode_q[MODE_PACKED] ? mode_q[MODE_SUB] : carry_q;

    addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a_i    (a_chunk),
        .b_i    (b_chunk),
        .cin_i  (cin),
        .s_o    (s_chunk),
        .cout_o (cout),
        .cmsb_o (cmsb)
    );

    assign v_cur = cmsb ^ cout;

    always_comb begin
        sum_run = sum_q;
        v_run   = v_q;
        for (int i = 0; i < NCHUNK; i++) begin
            if (cnt_q == CW'(i)) begin
                sum_run[i*CHUNK +: CHUNK] = s_chunk;
                v_run[i]                  = v_cur;
            end
        end
    end

    // ------------------------------------------------------------------
    // Final adjust: saturation direction follows the sign of A (of the
    // lane), which is the true sign of an overflowed add or subtract.
    // ------------------------------------------------------------------
    always_comb begin
        sum_fin  = sum_q;
        ovfl_fin = 1'b0;
        if (mode_q[MODE_PACKED]) begin
            ovfl_fin = |v_q;
            if (mode_q[MODE_SAT]) begin
                for (int i = 0; i < NCHUNK; i++) begin
                    if (v_q[i]) begin
                        sum_fin[i*CHUNK +: CHUNK] =
                            a_q[i*CHUNK + CHUNK - 1] ? LANE_MIN : LANE_MAX;
                    end
                end
            end
        end else begin
            ovfl_fin = v_q[NCHUNK-1];
            if (mode_q[MODE_SAT] && v_q[NCHUNK-1]) begin
                sum_fin = a_q[WIDTH-1] ? WORD_MIN : WORD_MAX;
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the operand and result registers are cleared too: the
            // visible Sum/flags must read zero after reset, and clearing the
            // operands keeps the whole datapath in a known state.
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            bx_q    <= '0;
            mode_q  <= '0;
            sum_q   <= '0;
            v_q     <= '0;
            ovfl_q  <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q     <= A;
                        bx_q    <= B ^ {WIDTH{sub}};
                        mode_q  <= encode_mode(packed_en, sat, sub);
                        cnt_q   <= '0;
                        carry_q <= sub;
                        v_q     <= '0;
                    end
                end
                RUN: begin
                    if (cnt_q != ADJ_CNT) begin
                        sum_q   <= sum_run;
                        v_q     <= v_run;
                        carry_q <= cout;
                        cnt_q   <= cnt_q + 1'b1;
                    end else begin
                        sum_q  <= sum_fin;
                        ovfl_q <= ovfl_fin;
                        zero_q <= (sum_fin == '0);
                        neg_q  <= sum_fin[WIDTH-1];
                    end
                end
                default: ;
            endcase
        end
    end

    assign Sum  = sum_q;
    assign Ovfl = ovfl_q;
    assign Zero = zero_q;
    assign Neg  = neg_q;

endmodule

// File: tb/tb_addsub_seq.sv
// ---------------------------------------------------------------------------
// tb_addsub_seq
// Bench for addsub_seq (WIDTH=16, CHUNK=4). An arithmetic model computes the
// expected result of each accepted operation with signed integer math per
// word or per lane; a compare process checks every out_valid cycle against
// the head of the expected queue and checks the accept-to-valid latency.
// ---------------------------------------------------------------------------
module tb_addsub_seq;

    localparam int W  = 16;
    localparam int C  = 4;
    localparam int NC = W / C;

    typedef struct {
        logic [W-1:0] sum;
        logic         ovfl;
        logic         zero;
        logic         neg;
        int           acc_cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         sub = 1'b0;
    logic         sat = 1'b0;
    logic         packed_en = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] Sum;
    logic         Ovfl, Zero, Neg;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   rdy_mode = 0;  // 0: always ready, 1: random, 2: held low
    bit   seen_valid = 1'b0;
    exp_t exp_q[$];

    addsub_seq #(.WIDTH(W), .CHUNK(C)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .sub       (sub),
        .sat       (sat),
        .packed_en (packed_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Sum       (Sum),
        .Ovfl      (Ovfl),
        .Zero      (Zero),
        .Neg       (Neg)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Sign-extend the low n bits of v.
    function automatic longint sext(input logic [W-1:0] v, input int n);
        longint x;
        x = 0;
        for (int k = 0; k < n; k++) x[k] = v[k];
        if (v[n-1]) x = x - (longint'(1) << n);
        return x;
    endfunction

    // Reference: signed add/sub per word or per lane, clamp if saturating.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input bit s, input bit st, input bit pk);
        exp_t   e;
        longint ai, bi, r, hi, lo;
        int     lw;
        e  = '{sum: '0, ovfl: 1'b0, zero: 1'b0, neg: 1'b0, acc_cyc: 0};
        lw = pk ? C : W;
        hi = (longint'(1) << (lw - 1)) - 1;
        lo = -hi - 1;
        for (int l = 0; l < W / lw; l++) begin
            ai = sext(a >> (l * lw), lw);
            bi = sext(b >> (l * lw), lw);
            r  = s ? ai - bi : ai + bi;
            if (r > hi || r < lo) begin
                e.ovfl = 1'b1;
                if (st) r = (r > hi) ? hi : lo;
            end
            for (int k = 0; k < lw; k++) e.sum[l*lw + k] = r[k];
        end
        e.zero = (e.sum == '0);
        e.neg  = e.sum[W-1];
        return e;
    endfunction

    // Compare process: every cycle with out_valid=1 is checked.
    always @(negedge clk) begin
        if (rst) begin
            seen_valid = 1'b0;
        end else if (out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", out_valid, 1'b0);
            end else begin
                if (!seen_valid) begin
                    check("latency", cyc - exp_q[0].acc_cyc, NC + 1);
                    seen_valid = 1'b1;
                end
                check("sum",  Sum,  exp_q[0].sum);
                check("ovfl", Ovfl, exp_q[0].ovfl);
                check("zero", Zero, exp_q[0].zero);
                check("neg",  Neg,  exp_q[0].neg);
                check("in_ready_done", in_ready, 1'b0);
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    seen_valid = 1'b0;
                end
            end
        end
    end

    // Consumer-side ready generator.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Present one operation and wait for its accept edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit s, input bit st, input bit pk, input bit push);
        exp_t e;
        int   n;
        n         = 0;
        in_valid  = 1'b1;
        A         = a;
        B         = b;
        sub       = s;
        sat       = st;
        packed_en = pk;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_idle", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        A        = W'($urandom);
        B        = W'($urandom);
        if (push) begin
            e         = model(a, b, s, st, pk);
            e.acc_cyc = cyc;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("result_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    function automatic logic [W-1:0] pick();
        logic [W-1:0] corners [4];
        corners[0] = 16'h7FFF;
        corners[1] = 16'h8000;
        corners[2] = 16'h0000;
        corners[3] = 16'hFFFF;
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 3)];
        return W'($urandom);
    endfunction

    initial begin
        exp_t e;

        // Pin the model to hand-computed results.
        e = model(16'h1234, 16'h0FFF, 0, 0, 0);
        check("pin1_sum", e.sum, 16'h2233);
        check("pin1_v", e.ovfl, 1'b0);
        e = model(16'h7FFF, 16'h0001, 0, 0, 0);
        check("pin2a_sum", e.sum, 16'h8000);
        check("pin2a_n", e.neg, 1'b1);
        e = model(16'h7FFF, 16'h0001, 0, 1, 0);
        check("pin2b_sum", e.sum, 16'h7FFF);
        check("pin2b_v", e.ovfl, 1'b1);
        e = model(16'h8000, 16'h0001, 1, 0, 0);
        check("pin3a_sum", e.sum, 16'h7FFF);
        e = model(16'h8000, 16'h0001, 1, 1, 0);
        check("pin3b_sum", e.sum, 16'h8000);
        e = model(16'h781F, 16'h1821, 0, 1, 1);
        check("pin4_sum", e.sum, 16'h7830);
        check("pin4_v", e.ovfl, 1'b1);
        e = model(16'h5A5A, 16'h5A5A, 1, 0, 0);
        check("pin5_z", e.zero, 1'b1);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_sum", Sum, 16'h0000);
        check("rst_ovfl", Ovfl, 1'b0);
        check("rst_zero", Zero, 1'b0);
        check("rst_neg", Neg, 1'b0);
        @(posedge clk);
        #1;

        // Directed operations.
        issue(16'h1234, 16'h0FFF, 0, 0, 0, 1); wait_drain();
        issue(16'h7FFF, 16'h0001, 0, 0, 0, 1); wait_drain();
        issue(16'h7FFF, 16'h0001, 0, 1, 0, 1); wait_drain();
        issue(16'h8000, 16'h0001, 1, 0, 0, 1); wait_drain();
        issue(16'h8000, 16'h0001, 1, 1, 0, 1); wait_drain();
        issue(16'h781F, 16'h1821, 0, 1, 1, 1); wait_drain();
        issue(16'h8F70, 16'h1111, 1, 0, 1, 1); wait_drain();

        // in_valid pulsed during RUN must be ignored.
        issue(16'h5A5A, 16'h5A5A, 1, 0, 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        @(negedge clk);
        check("in_ready_run1", in_ready, 1'b0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("in_ready_run2", in_ready, 1'b0);
        in_valid = 1'b0;
        wait_drain();
        repeat (NC + 3) @(posedge clk);
        #1;

        // Hold out_ready low in DONE; compare process checks stability.
        rdy_mode = 2;
        @(posedge clk);
        #1;
        issue(16'hC001, 16'h4002, 0, 0, 0, 1);
        repeat (NC + 1 + 3) @(posedge clk);
        @(negedge clk);
        check("hold_out_valid", out_valid, 1'b1);
        rdy_mode = 0;
        wait_drain();

        // Reset in the 2nd RUN cycle abandons the operation.
        issue(16'h1111, 16'h2222, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_in_ready", in_ready, 1'b1);
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_sum", Sum, 16'h0000);
        repeat (NC + 4) @(posedge clk);
        #1;

        // Randomized operations with a randomly stalling consumer.
        rdy_mode = 1;
        for (int i = 0; i < 60; i++) begin
            issue(pick(), pick(), 1'($urandom), 1'($urandom), 1'($urandom), 1);
            wait_drain();
            if ($urandom_range(0, 2) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rdy_mode = 0;
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
